// File: rtl/lsu.sv
// Load/store unit: decodes RV32 loads and stores, runs one data-memory access at a time,
// and returns extended load data or an error to writeback.
module lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [16:0] req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_we,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateType;

    stateType    stateReg, stateNext;
    logic        accept, timeoutHit;
    logic [7:0]  cntReg;

    logic [2:0]  f3Reg;
    logic [1:0]  offsetReg;
    logic        isLoadReg;
    logic [4:0]  rdReg;
    logic        memWeReg;
    logic [31:0] memAddrReg, memWdataReg;
    logic [3:0]  memWstrbReg;
    logic [31:0] rspDataReg;
    logic        rspWeReg, rspErrReg;

    // Request decode
    logic [2:0]  reqF3;
    logic [6:0]  reqOpcode;
    logic        reqIsLoad, reqIsStore, reqLegalF3, reqMisaligned, reqErr;
    logic [3:0]  reqWstrb;
    logic [31:0] reqLaneData;
    logic        unusedFunct7;

    assign reqF3        = req_op[9:7];
    assign reqOpcode    = req_op[6:0];
    assign unusedFunct7 = ^req_op[16:10];
    assign reqIsLoad    = (reqOpcode == 7'b0000011);
    assign reqIsStore   = (reqOpcode == 7'b0100011);

    always_comb begin
        reqLegalF3 = 1'b0;
        if (reqIsLoad)
            reqLegalF3 = (reqF3 == 3'b000) || (reqF3 == 3'b001) || (reqF3 == 3'b010) ||
                         (reqF3 == 3'b100) || (reqF3 == 3'b101);
        else if (reqIsStore)
            reqLegalF3 = (reqF3 == 3'b000) || (reqF3 == 3'b001) || (reqF3 == 3'b010);
    end

    assign reqMisaligned = ((reqF3[1:0] == 2'b01) && req_addr[0]) ||
                           ((reqF3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign reqErr        = !reqLegalF3 || reqMisaligned;

    always_comb begin
        reqWstrb = 4'b0000;
        if (reqIsStore) begin
            case (reqF3[1:0])
                2'b00:   reqWstrb = 4'b0001 << req_addr[1:0];
                2'b01:   reqWstrb = 4'b0011 << req_addr[1:0];
                default: reqWstrb = 4'b1111;
            endcase
        end
    end

    // Replicate the store byte/half across every lane so the strobe alone picks the target.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : genLane
            always_comb begin
                case (reqF3[1:0])
                    2'b00:   reqLaneData[8*gi +: 8] = req_wdata[7:0];
                    2'b01:   reqLaneData[8*gi +: 8] = req_wdata[8*(gi%2) +: 8];
                    default: reqLaneData[8*gi +: 8] = req_wdata[8*gi +: 8];
                endcase
            end
        end
    endgenerate

    // Load extraction
    logic [31:0] shifted, loadData;
    assign shifted = mem_rdata >> {offsetReg, 3'b000};

    always_comb begin
        case (f3Reg)
            3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  loadData = {24'd0, shifted[7:0]};
            3'b101:  loadData = {16'd0, shifted[15:0]};
            default: loadData = mem_rdata;
        endcase
    end

    // A late ack on the final allowed cycle still completes the access.
    assign timeoutHit = !mem_ack && (cntReg == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stateReg <= IDLE;
        else     stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        accept    = 1'b0;
        case (stateReg)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    stateNext = reqErr ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack || timeoutHit) stateNext = RESP;
            end
            RESP: begin
                if (rsp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntReg      <= '0;
            f3Reg       <= '0;
            offsetReg   <= '0;
            isLoadReg   <= 1'b0;
            rdReg       <= '0;
            memWeReg    <= 1'b0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            memWstrbReg <= '0;
            rspDataReg  <= '0;
            rspWeReg    <= 1'b0;
            rspErrReg   <= 1'b0;
        end else begin
            if (accept) begin
                cntReg      <= '0;
                f3Reg       <= reqF3;
                offsetReg   <= req_addr[1:0];
                isLoadReg   <= reqIsLoad;
                rdReg       <= req_rd;
                memWeReg    <= reqIsStore;
                memAddrReg  <= {req_addr[31:2], 2'b00};
                memWdataReg <= reqIsStore ? reqLaneData : 32'd0;
                memWstrbReg <= reqWstrb;
                rspDataReg  <= '0;
                rspWeReg    <= 1'b0;
                rspErrReg   <= reqErr;
            end else if (stateReg == ACCESS) begin
                if (mem_ack) begin
                    rspDataReg <= isLoadReg ? loadData : 32'd0;
                    rspWeReg   <= isLoadReg && (rdReg != 5'd0);
                    rspErrReg  <= 1'b0;
                end else if (timeoutHit) begin
                    rspDataReg <= '0;
                    rspWeReg   <= 1'b0;
                    rspErrReg  <= 1'b1;
                end else begin
                    cntReg <= cntReg + 8'd1;
                end
            end
        end
    end

    assign req_ready = (stateReg == IDLE) && !rst;

    assign mem_req   = (stateReg == ACCESS);
    assign mem_we    = mem_req && memWeReg;
    assign mem_addr  = mem_req ? memAddrReg  : 32'd0;
    assign mem_wdata = mem_req ? memWdataReg : 32'd0;
    assign mem_wstrb = mem_req ? memWstrbReg : 4'd0;

    assign rsp_valid = (stateReg == RESP);
    assign rsp_data  = rsp_valid ? rspDataReg : 32'd0;
    assign rsp_rd    = rsp_valid ? rdReg      : 5'd0;
    assign rsp_we    = rsp_valid && rspWeReg;
    assign rsp_err   = rsp_valid && rspErrReg;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of single transactions plus hand-written
// timeout, back-pressure and mid-access reset sequences.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [16:0] req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_we;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    lsu #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_we(rsp_we), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          ackDelay;
        bit          access;
        logic [31:0] eMemAddr;
        logic [3:0]  eWstrb;
        logic [31:0] eWdata;
        bit          eWe;
        logic [31:0] eData;
        bit          eRspWe;
        bit          eErr;
    } vecType;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    vecType vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends just after a rising edge; outputs are sampled on the falling edge.
    task automatic runVec(input int idx);
        vecType v;
        v = vecs[idx];
        req_valid = 1'b1; req_op = v.op; req_addr = v.addr;
        req_wdata = v.wdata; req_rd = v.rd; rsp_ready = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d req_ready", idx), {31'd0, req_ready}, 32'd1);
        nextCycle();
        req_valid = 1'b0;
        if (v.access) begin
            for (int j = 0; j <= v.ackDelay; j++) begin
                if (j == v.ackDelay) begin
                    mem_ack = 1'b1; mem_rdata = v.rdata;
                end
                @(negedge clk);
                check($sformatf("v%0d mem_req", idx), {31'd0, mem_req}, 32'd1);
                check($sformatf("v%0d mem_addr", idx), mem_addr, v.eMemAddr);
                check($sformatf("v%0d mem_wstrb", idx), {28'd0, mem_wstrb}, {28'd0, v.eWstrb});
                check($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, v.eWe});
                if (v.eWe)
                    check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.eWdata);
                check($sformatf("v%0d req_ready busy", idx), {31'd0, req_ready}, 32'd0);
                nextCycle();
                mem_ack = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("v%0d rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
        check($sformatf("v%0d mem_req off", idx), {31'd0, mem_req}, 32'd0);
        check($sformatf("v%0d rsp_data", idx), rsp_data, v.eData);
        check($sformatf("v%0d rsp_we", idx), {31'd0, rsp_we}, {31'd0, v.eRspWe});
        check($sformatf("v%0d rsp_err", idx), {31'd0, rsp_err}, {31'd0, v.eErr});
        check($sformatf("v%0d rsp_rd", idx), {27'd0, rsp_rd}, {27'd0, v.rd});
        $display("txn %0d op=%h addr=%h rsp_data=%h we=%0b err=%0b", idx, v.op, v.addr,
                 rsp_data, rsp_we, rsp_err);
        nextCycle();
        @(negedge clk);
        check($sformatf("v%0d back idle", idx), {31'd0, req_ready}, 32'd1);
        nextCycle();
    endtask

    // Issues an LW with no ack; optionally acks on the 16th access cycle.
    task automatic runTimeout(input bit ackLast);
        int cnt;
        bit done;
        cnt = 0; done = 1'b0;
        req_valid = 1'b1; req_op = {7'd0, 3'b010, LD}; req_addr = 32'h0000_8000;
        req_rd = 5'd9; rsp_ready = 1'b1;
        nextCycle();
        req_valid = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (mem_req) cnt++;
                if (ackLast && cnt == 16) begin
                    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
                end
                nextCycle();
                mem_ack = 1'b0;
            end
        end
        check("timeout reached rsp", {31'd0, done}, 32'd1);
        check("timeout mem_req cycles", cnt, 32'd16);
        check("timeout rsp_err", {31'd0, rsp_err}, {31'd0, !ackLast});
        check("timeout rsp_data", rsp_data, ackLast ? 32'h1122_3344 : 32'd0);
        $display("txn timeout ackLast=%0b cycles=%0d err=%0b data=%h", ackLast, cnt, rsp_err, rsp_data);
        nextCycle();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        req_rd = '0; mem_ack = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;

        vecs[0]  = '{{7'd0,3'b000,LD}, 32'h1003, 32'h0, 5'd5,  32'h8012_3456, 0, 1, 32'h1000, 4'b0000, 32'h0,         0, 32'hFFFF_FF80, 1, 0};
        vecs[1]  = '{{7'd0,3'b100,LD}, 32'h1003, 32'h0, 5'd5,  32'h8012_3456, 0, 1, 32'h1000, 4'b0000, 32'h0,         0, 32'h0000_0080, 1, 0};
        vecs[2]  = '{{7'd0,3'b001,ST}, 32'h2002, 32'h0000_BEEF, 5'd4, 32'h0,  0, 1, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0,         0, 0};
        vecs[3]  = '{{7'd0,3'b010,LD}, 32'h2001, 32'h0, 5'd6,  32'h0,         0, 0, 32'h0,    4'b0000, 32'h0,         0, 32'h0,         0, 1};
        vecs[4]  = '{{7'd0,3'b001,LD}, 32'h3002, 32'h0, 5'd10, 32'h8001_7FFF, 1, 1, 32'h3000, 4'b0000, 32'h0,         0, 32'hFFFF_8001, 1, 0};
        vecs[5]  = '{{7'd0,3'b101,LD}, 32'h3000, 32'h0, 5'd11, 32'h8001_F00D, 0, 1, 32'h3000, 4'b0000, 32'h0,         0, 32'h0000_F00D, 1, 0};
        vecs[6]  = '{{7'd0,3'b010,LD}, 32'h4004, 32'h0, 5'd0,  32'hDEAD_BEEF, 0, 1, 32'h4004, 4'b0000, 32'h0,         0, 32'hDEAD_BEEF, 0, 0};
        vecs[7]  = '{{7'd0,3'b000,ST}, 32'h5001, 32'h1234_56AB, 5'd2, 32'h0,  0, 1, 32'h5000, 4'b0010, 32'hABAB_ABAB, 1, 32'h0,         0, 0};
        vecs[8]  = '{{7'd0,3'b010,ST}, 32'h6000, 32'hCAFE_F00D, 5'd3, 32'h0,  3, 1, 32'h6000, 4'b1111, 32'hCAFE_F00D, 1, 32'h0,         0, 0};
        vecs[9]  = '{{7'd0,3'b000,7'b0110011}, 32'h7000, 32'h0, 5'd1, 32'h0,  0, 0, 32'h0,    4'b0000, 32'h0,         0, 32'h0,         0, 1};
        vecs[10] = '{{7'd0,3'b011,LD}, 32'h7000, 32'h0, 5'd1,  32'h0,         0, 0, 32'h0,    4'b0000, 32'h0,         0, 32'h0,         0, 1};
        vecs[11] = '{{7'd0,3'b100,ST}, 32'h7000, 32'h0, 5'd1,  32'h0,         0, 0, 32'h0,    4'b0000, 32'h0,         0, 32'h0,         0, 1};
        vecs[12] = '{{7'd0,3'b001,LD}, 32'h3001, 32'h0, 5'd1,  32'h0,         0, 0, 32'h0,    4'b0000, 32'h0,         0, 32'h0,         0, 1};
        vecs[13] = '{{7'd0,3'b000,LD}, 32'h7001, 32'h0, 5'd8,  32'h0000_7F00, 2, 1, 32'h7000, 4'b0000, 32'h0,         0, 32'h0000_007F, 1, 0};

        repeat (2) @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 32'd0);
        check("reset mem_req", {31'd0, mem_req}, 32'd0);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        check("release req_ready", {31'd0, req_ready}, 32'd1);
        nextCycle();

        // An ack while idle must not disturb anything.
        mem_ack = 1'b1;
        nextCycle();
        mem_ack = 1'b0;
        @(negedge clk);
        check("stray ack rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("stray ack req_ready", {31'd0, req_ready}, 32'd1);
        nextCycle();

        for (int i = 0; i < 14; i++) runVec(i);

        runTimeout(1'b0);
        runTimeout(1'b1);

        // Back-pressure: response must hold while rsp_ready is low.
        req_valid = 1'b1; req_op = {7'd0, 3'b010, LD}; req_addr = 32'h100;
        req_rd = 5'd7; rsp_ready = 1'b0;
        nextCycle();
        req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
        nextCycle();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
            @(negedge clk);
            check("stall rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall rsp_data", rsp_data, 32'hA5A5_5A5A);
            check("stall rsp_rd", {27'd0, rsp_rd}, 32'd7);
            check("stall rsp_we", {31'd0, rsp_we}, 32'd1);
            check("stall req_ready", {31'd0, req_ready}, 32'd0);
            check("stall mem_req", {31'd0, mem_req}, 32'd0);
            nextCycle();
        end
        mem_ack = 1'b0; rsp_ready = 1'b1;
        nextCycle();
        @(negedge clk);
        check("stall release rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("stall release req_ready", {31'd0, req_ready}, 32'd1);
        $display("txn stall held 5 cycles data=%h", 32'hA5A5_5A5A);
        nextCycle();

        // Reset in the middle of ACCESS aborts without a response.
        req_valid = 1'b1; req_op = {7'd0, 3'b010, ST}; req_addr = 32'h200;
        req_wdata = 32'h5555_AAAA; req_rd = 5'd1;
        nextCycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("abort mem_req before", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort mem_req dropped", {31'd0, mem_req}, 32'd0);
        check("abort mem_we dropped", {31'd0, mem_we}, 32'd0);
        check("abort req_ready in rst", {31'd0, req_ready}, 32'd0);
        nextCycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort no rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("abort req_ready", {31'd0, req_ready}, 32'd1);
            nextCycle();
        end
        $display("txn reset-abort done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 16, is the number of ACCESS cycles without mem_ack before the transaction aborts; legal range is 1..255.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  request from the execute stage.
REQ-005 req_ready  out  1  lsu can accept a request.
REQ-006 req_op  in  17  instruction bundle: [16:10] funct7, [9:7] funct3, [6:0] opcode.
REQ-007 req_addr  in  32  effective address, i.e. the ALU add result.
REQ-008 req_wdata  in  32  store data (rs2).
REQ-009 req_rd  in  5  destination register.
REQ-010 mem_req  out  1  data-memory request.
REQ-011 mem_we  out  1  1 = write.
REQ-012 mem_addr  out  32  word-aligned address.
REQ-013 mem_wdata  out  32  lane-replicated write data.
REQ-014 mem_wstrb  out  4  byte enables.
REQ-015 mem_ack  in  1  memory completes the access.
REQ-016 mem_rdata  in  32  read word, valid with mem_ack.
REQ-017 rsp_valid  out  1  response to writeback.
REQ-018 rsp_ready  in  1  writeback accepts the response.
REQ-019 rsp_data  out  32  extended load data; 0 for stores and errors.
REQ-020 rsp_rd  out  5  captured req_rd.
REQ-021 rsp_we  out  1  register write enable.
REQ-022 rsp_err  out  1  illegal op, misaligned access or timeout.

Function
REQ-023 The FSM SHALL have three states, IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE, mem_req only in ACCESS, and rsp_valid only in RESP.
REQ-024 On req_valid&&req_ready the lsu SHALL capture op, addr, wdata and rd, and SHALL take no further request until it returns to IDLE.
REQ-025 Opcode decode: 0000011 is a load with funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 0100011 is a store with funct3 000 SB, 001 SH, 010 SW.
REQ-026 Error path (IDLE->RESP, err=1, no bus access): any other opcode or funct3; a half access with addr[0]=1; a word access with addr[1:0]!=0.
REQ-027 A legal request SHALL go IDLE->ACCESS; mem_addr={addr[31:2],2'b00}; mem_we=1 for stores.
REQ-028 Store lanes: SB sets wstrb 0001<<addr[1:0] and wdata {4{wdata[7:0]}}; SH sets wstrb 0011<<addr[1:0] and wdata {2{wdata[15:0]}}; SW sets wstrb 1111; loads drive wstrb 0000.
REQ-029 mem_req and all mem_* outputs SHALL be held stable throughout ACCESS until mem_ack; in IDLE and RESP all mem_* outputs SHALL be 0.
REQ-030 mem_ack sampled in ACCESS SHALL move the FSM to RESP; mem_req SHALL be 0 the following cycle; mem_ack in any other state SHALL be ignored.
REQ-031 Load extraction: take the byte or half starting at bit 8*addr[1:0] of mem_rdata; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through; the result is registered on mem_ack.
REQ-032 A cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack; on reaching TIMEOUT the FSM SHALL go to RESP with err=1 and rsp_data=0.
REQ-033 If mem_ack and timeout coincide in the same cycle, the ack SHALL win (err=0).
REQ-034 rsp_we SHALL be 1 only for an error-free load with rd!=0.
REQ-035 In RESP all rsp_* outputs SHALL be held stable until rsp_ready; RESP->IDLE on rsp_valid&&rsp_ready.
REQ-036 Latency: accept at cycle N, ack at N+1 gives rsp_valid at N+2; the error path gives rsp_valid at N+1.

Reset
REQ-037 While rst=1, asynchronously, state SHALL be IDLE and every output SHALL be 0 except req_ready.
REQ-038 req_ready SHALL be 0 while rst=1 and 1 after release.
REQ-039 Reset asserted mid-transaction SHALL abort it with no response and mem_req dropping immediately.

Verification
REQ-040 LB addr 0x1003, mem_rdata 0x80123456 -> mem_addr 0x1000, wstrb 0000, rsp_data 0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-041 SH addr 0x2002, wdata 0x0000BEEF -> mem_we 1, wstrb 1100, mem_wdata 0xBEEFBEEF, rsp_we 0, rsp_data 0.
REQ-042 LW addr 0x2001 -> mem_req never asserted; rsp_valid 1 cycle after accept with rsp_err 1.
REQ-043 TIMEOUT=16 with no mem_ack -> exactly 16 cycles of mem_req, then rsp_err 1 and rsp_data 0.
REQ-044 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req_ready 0; rsp_ready=1 -> IDLE next cycle.
REQ-045 rst pulsed during ACCESS -> mem_req 0 in the same cycle, no rsp_valid, req_ready 1 after release.
